// File: rtl/lfsr_seq.sv
// lfsr_seq -- LFSR sequencer for the program-2 core.
//
// Owns the LFSR state and tap-pattern registers. Executes one command at a
// time over a ready/valid handshake: set seed, set taps, clear, and a
// multi-step shift. Each accepted command ends with a one-cycle Done pulse.
//
// Parameters:
//   WIDTH  LFSR width in bits (2..8)
//   CNT_W  width of the shift-count field taken from CmdData
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset     in   synchronous, active-high reset
//   CmdValid  in   command presented
//   CmdOp     in   00 set seed, 01 set taps, 10 shift, 11 clear
//   CmdData   in   seed/taps in [WIDTH-1:0], shift count in [CNT_W-1:0]
//   CmdReady  out  sequencer idle and able to accept a command
//   State     out  current LFSR state
//   TapPtrn   out  current tap pattern
//   Busy      out  multi-step shift in progress
//   Done      out  one-cycle pulse when the accepted command completes
//   ZeroSeed  out  sticky zero-seed flag (only with LFSR_SEQ_ZERO_GUARD_EN)
//
// Build option:
//   LFSR_SEQ_ZERO_GUARD_EN  when defined, an all-zero seed loads 1 instead
//                           and sets the sticky ZeroSeed flag.

module lfsr_seq #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  input  logic [1:0]       CmdOp,
  input  logic [7:0]       CmdData,
  output logic             CmdReady,
  output logic [WIDTH-1:0] State,
  output logic [WIDTH-1:0] TapPtrn,
  output logic             Busy,
`ifdef LFSR_SEQ_ZERO_GUARD_EN
  output logic             ZeroSeed,
`endif
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fsm_t;

  localparam logic [1:0] OP_SEED  = 2'b00;
  localparam logic [1:0] OP_TAPS  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  fsm_t             fsm_reg;
  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] tap_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             zero_seed_reg;

  logic [WIDTH-1:0] tap_hits;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] seed_next;
  logic             seed_is_zero;
  logic [CNT_W-1:0] count_in;
  logic             data_unused;

  // Per-bit tap products; their XOR is the feedback bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tap_hits[gi] = state_reg[gi] & tap_reg[gi];
    end
  endgenerate

  assign step_next    = {state_reg[WIDTH-2:0], ^tap_hits};
  assign count_in     = CmdData[CNT_W-1:0];
  assign seed_is_zero = (CmdData[WIDTH-1:0] == '0);
  // Upper CmdData bits are don't-care for the narrower fields.
  assign data_unused  = ^CmdData;

`ifdef LFSR_SEQ_ZERO_GUARD_EN
  // A zero seed would lock the LFSR at zero; substitute 1 and flag it.
  assign seed_next = seed_is_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : CmdData[WIDTH-1:0];
`else
  assign seed_next = CmdData[WIDTH-1:0];
`endif

  // Single FSM block; handshake/status outputs are registered alongside the
  // state so they always match the state the FSM is entering.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_reg       <= ST_IDLE;
      state_reg     <= '0;
      tap_reg       <= '0;
      cnt_reg       <= '0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      zero_seed_reg <= 1'b0;
    end else begin
      case (fsm_reg)
        ST_IDLE: begin
          if (CmdValid) begin
            // Default outcome: complete in one cycle via DONE.
            fsm_reg   <= ST_DONE;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            case (CmdOp)
              OP_SEED: begin
                state_reg <= seed_next;
                if (seed_is_zero) zero_seed_reg <= 1'b1;
              end
              OP_TAPS: begin
                tap_reg <= CmdData[WIDTH-1:0];
              end
              OP_CLEAR: begin
                state_reg     <= '0;
                tap_reg       <= '0;
                zero_seed_reg <= 1'b0;
              end
              OP_SHIFT: begin
                if (count_in != '0) begin
                  cnt_reg  <= count_in;
                  fsm_reg  <= ST_SHIFT;
                  busy_reg <= 1'b1;
                  done_reg <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          state_reg <= step_next;
          cnt_reg   <= cnt_reg - 1'b1;
          // Counter still holds the steps remaining including this one.
          if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            fsm_reg  <= ST_DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          fsm_reg   <= ST_IDLE;
          ready_reg <= 1'b1;
          done_reg  <= 1'b0;
        end
        default: begin
          fsm_reg   <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign CmdReady = ready_reg;
  assign State    = state_reg;
  assign TapPtrn  = tap_reg;
  assign Busy     = busy_reg;
  assign Done     = done_reg;

`ifdef LFSR_SEQ_ZERO_GUARD_EN
  assign ZeroSeed = zero_seed_reg;
`else
  logic zero_seed_unused;
  assign zero_seed_unused = zero_seed_reg;
`endif

endmodule

// File: tb/tb_lfsr_seq.sv
// tb_lfsr_seq -- self-checking bench for lfsr_seq.
// Directed scenarios followed by randomized commands, all checked against a
// behavioural model that works on plain integers.

module tb_lfsr_seq;

  localparam int WIDTH = 7;
  localparam int CNT_W = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             CmdValid;
  logic [1:0]       CmdOp;
  logic [7:0]       CmdData;
  logic             CmdReady;
  logic [WIDTH-1:0] State;
  logic [WIDTH-1:0] TapPtrn;
  logic             Busy;
  logic             Done;
`ifdef LFSR_SEQ_ZERO_GUARD_EN
  logic             ZeroSeed;
`endif

  lfsr_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdOp    (CmdOp),
    .CmdData  (CmdData),
    .CmdReady (CmdReady),
    .State    (State),
    .TapPtrn  (TapPtrn),
    .Busy     (Busy),
`ifdef LFSR_SEQ_ZERO_GUARD_EN
    .ZeroSeed (ZeroSeed),
`endif
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_state = 0;
  int m_taps  = 0;
  int m_zs    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One LFSR step from first principles: shift left within WIDTH bits and
  // append the parity of the tapped bits.
  function automatic int lfsr_step(input int s, input int t);
    int par;
    par = $countones(s & t) % 2;
    return ((s << 1) | par) & MASK;
  endfunction

  task automatic check_zs();
`ifdef LFSR_SEQ_ZERO_GUARD_EN
    check("zero_seed", int'(ZeroSeed), m_zs);
`endif
  endtask

  // Issue one command; caller is at a negedge with the sequencer idle-or-busy.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data);
    int n;
    int waited;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    waited   = 0;
    while (!CmdReady && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (!CmdReady) begin
      check("accept_timeout", 0, 1);
      CmdValid = 1'b0;
      return;
    end
    @(negedge Clk);   // accept edge T has passed
    CmdValid = 1'b0;
    n = 0;
    case (op)
      2'b00: begin
        if ((int'(data) & MASK) == 0) begin
`ifdef LFSR_SEQ_ZERO_GUARD_EN
          m_state = 1;
          m_zs    = 1;
`else
          m_state = 0;
`endif
        end else begin
          m_state = int'(data) & MASK;
        end
      end
      2'b01: m_taps = int'(data) & MASK;
      2'b11: begin
        m_state = 0;
        m_taps  = 0;
        m_zs    = 0;
      end
      default: n = int'(data) & ((1 << CNT_W) - 1);
    endcase
    for (int k = 0; k < n; k++) begin
      check("busy", int'(Busy), 1);
      check("done_mid", int'(Done), 0);
      check("ready_mid", int'(CmdReady), 0);
      check("state_mid", int'(State), m_state);
      @(negedge Clk);
      m_state = lfsr_step(m_state, m_taps);
    end
    check("done", int'(Done), 1);
    check("busy_end", int'(Busy), 0);
    check("ready_done", int'(CmdReady), 0);
    check("state", int'(State), m_state);
    check("taps", int'(TapPtrn), m_taps);
    check_zs();
    $display("cmd op=%0d data=0x%02h steps=%0d -> state=0x%02h taps=0x%02h",
             op, data, n, State, TapPtrn);
    @(negedge Clk);
    check("done_clear", int'(Done), 0);
    check("ready_back", int'(CmdReady), 1);
  endtask

  initial begin
    Reset    = 1'b1;
    CmdValid = 1'b0;
    CmdOp    = 2'b00;
    CmdData  = 8'h00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Reset values while idle.
    check("rst_ready", int'(CmdReady), 1);
    check("rst_state", int'(State), 0);
    check("rst_taps", int'(TapPtrn), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check_zs();

    // Set and shift: taps 0x60, seed 0x01, N=3 -> 0x08.
    do_cmd(2'b01, 8'h60);
    do_cmd(2'b00, 8'h01);
    do_cmd(2'b10, 8'h03);
    check("shift3_fixed", int'(State), 'h08);

    // Feedback path: N=6 from 0x01 -> 0x41.
    do_cmd(2'b00, 8'h01);
    do_cmd(2'b10, 8'h06);
    check("shift6_fixed", int'(State), 'h41);

    // Zero count: state unchanged.
    do_cmd(2'b10, 8'h00);
    check("shift0_fixed", int'(State), 'h41);

    // A command held during SHIFT waits for IDLE, then executes once.
    CmdValid = 1'b1;
    CmdOp    = 2'b10;
    CmdData  = 8'h04;
    @(negedge Clk);
    CmdOp    = 2'b00;
    CmdData  = 8'h55;
    for (int k = 0; k < 4; k++) begin
      check("hold_busy", int'(Busy), 1);
      check("hold_state", int'(State), m_state);
      @(negedge Clk);
      m_state = lfsr_step(m_state, m_taps);
    end
    check("hold_done", int'(Done), 1);
    check("hold_shifted", int'(State), m_state);
    @(negedge Clk);
    check("hold_ready", int'(CmdReady), 1);
    check("hold_state_idle", int'(State), m_state);
    @(negedge Clk);
    CmdValid = 1'b0;
    m_state  = 'h55;
    check("hold_exec_done", int'(Done), 1);
    check("hold_exec_state", int'(State), m_state);
    @(negedge Clk);
    check("hold_once_done", int'(Done), 0);
    check("hold_once_ready", int'(CmdReady), 1);
    $display("cmd held seed 0x55 behind shift -> state=0x%02h", State);

    // Reset abort on the 2nd shift edge of an N=5 shift.
    CmdValid = 1'b1;
    CmdOp    = 2'b10;
    CmdData  = 8'h05;
    @(negedge Clk);      // accepted
    CmdValid = 1'b0;
    check("abort_busy", int'(Busy), 1);
    @(negedge Clk);      // first shift edge done
    Reset = 1'b1;
    @(negedge Clk);      // reset sampled on second shift edge
    Reset = 1'b0;
    m_state = 0;
    m_taps  = 0;
    m_zs    = 0;
    check("abort_done", int'(Done), 0);
    check("abort_busy0", int'(Busy), 0);
    check("abort_ready", int'(CmdReady), 1);
    check("abort_state", int'(State), 0);
    check("abort_taps", int'(TapPtrn), 0);
    check_zs();
    @(negedge Clk);
    check("abort_no_done", int'(Done), 0);
    $display("reset abort of shift N=5 -> state=0x%02h", State);

    // Zero seed handling (guarded or not, the model knows which).
    do_cmd(2'b00, 8'h00);
`ifdef LFSR_SEQ_ZERO_GUARD_EN
    check("zero_seed_state", int'(State), 1);
`else
    check("zero_seed_state", int'(State), 0);
`endif
    do_cmd(2'b11, 8'hFF);
    check("clear_state", int'(State), 0);

    // Randomized command stream.
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] d;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r <= 2) begin
        op = 2'b00;
        if ($urandom_range(0, 7) == 0) d = d & 8'h80;
      end else if (r <= 4) begin
        op = 2'b01;
      end else if (r <= 8) begin
        op = 2'b10;
      end else begin
        op = 2'b11;
      end
      do_cmd(op, d);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
